// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data RAM with sized/extended loads, lane-masked stores, handshake and sticky error capture
// clk, reset          : rising-edge clock, synchronous active-high reset
// req_i, ready_o      : request handshake, accepted when both are high at an edge
// we_i, size_i        : store/load select, access size (00 byte, 01 half, 10 word, 11 reserved)
// unsigned_i          : zero-extend (1) or sign-extend (0) sub-word loads
// addr_i, wdata_i     : byte address, right-justified store data
// rvalid_o, rdata_o   : one-cycle load response pulse and held extended load data
// err_o, err_addr_o   : sticky error flag and address of first error since last clear
// err_clr_i           : clears err_o and err_addr_o (a simultaneous new error wins)
module data_memory_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  input  logic                  err_clr_i
);
  localparam int unsigned IW = $clog2(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * MEMORY_DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
  logic                  ready_q, rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ADDR_WIDTH-1:0] off;
  logic [IW-1:0]         idx;
  logic [1:0]            lane;
  logic                  in_range, misalign, bad, acc, do_st, do_ld;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlanes, mask, word, merged, ldata;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  always_comb begin
    off = addr_i - BASE_ADDR;
    idx = off[IW+1:2];
    lane = addr_i[1:0];
    // addr_i >= BASE_ADDR rejects addresses below the segment that wrap into a small off
    in_range = (addr_i >= BASE_ADDR) && (off < SPAN);
    misalign = (size_i == 2'b01 && lane[0]) || (size_i == 2'b10 && lane != 2'b00) || size_i == 2'b11;
    bad = !in_range || misalign;
    acc = req_i && ready_q;
    do_st = acc && we_i && !bad;
    do_ld = acc && !we_i;
    be = size_i == 2'b00 ? 4'b0001 << lane : size_i == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlanes = size_i == 2'b00 ? {4{wdata_i[7:0]}} : size_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    word = mem_q[idx];
    merged = (wlanes & mask) | (word & ~mask);
    bsel = word[{lane, 3'b000} +: 8];
    hsel = lane[1] ? word[31:16] : word[15:0];
    ldata = size_i == 2'b00 ? {{24{!unsigned_i && bsel[7]}}, bsel}
          : size_i == 2'b01 ? {{16{!unsigned_i && hsel[15]}}, hsel} : word;
    rvalid_d = do_ld;
    rdata_d = do_ld ? (bad ? '0 : ldata) : rdata_q;
    err_d = acc && bad ? 1'b1 : err_clr_i ? 1'b0 : err_q;
    err_addr_d = acc && bad && (!err_q || err_clr_i) ? addr_i : err_clr_i ? '0 : err_addr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      ready_q <= 1'b1;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && do_st) mem_q[idx] <= merged;
  assign ready_o = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
  assign err_o = err_q;
  assign err_addr_o = err_addr_q;
endmodule
